// File: rtl/eth_pkg.sv
// Shared Ethernet header constants, types and helpers for the parser stages.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;
  localparam logic [15:0] ETH_TYPE_QINQ = 16'h88A8;
  localparam int unsigned ETH_HDR_LEN   = 14;
  localparam int unsigned VLAN_TAG_LEN  = 4;

  typedef logic [47:0] mac_addr_t;

  typedef enum logic [2:0] {
    S_DST,
    S_SRC,
    S_TYPE,
    S_TCI,
    S_DONE
  } eth_state_e;

  function automatic logic is_tpid(input logic [15:0] t);
    return (t == ETH_TYPE_VLAN) || (t == ETH_TYPE_QINQ);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage ready/valid pipeline register; holds its beat while downstream stalls.
module axis_reg_slice #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [IDX_W-1:0]      s_idx,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [IDX_W-1:0]      m_idx,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  valid_q;
  logic                  last_q;

  assign s_tready = m_tready || !valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (s_tready) begin
      valid_q <= s_tvalid;
      if (s_tvalid) begin
        data_q <= s_tdata;
        idx_q  <= s_idx;
        last_q <= s_tlast;
      end
    end
  end

  assign m_tdata  = data_q;
  assign m_idx    = idx_q;
  assign m_tvalid = valid_q;
  assign m_tlast  = last_q;

endmodule

// File: rtl/eth_hdr_parser_vlan.sv
// Ethernet header parser with stacked VLAN tags behind a ready/valid register slice.
// Define ETH_HDR_STATS_EN to add packet/VLAN/runt statistics counters.
module eth_hdr_parser_vlan
  import eth_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned MAX_VLAN   = 2,
  localparam int unsigned IDX_W      = $clog2(DATA_WIDTH / 8),
  localparam int unsigned VC_W       = (MAX_VLAN > 0) ? $clog2(MAX_VLAN + 1) : 1,
  localparam int unsigned TCI_W      = (MAX_VLAN > 0) ? 16 * MAX_VLAN : 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [IDX_W-1:0]      s_idx,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [IDX_W-1:0]      m_idx,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [47:0]           dst_mac,
  output logic [47:0]           src_mac,
  output logic [15:0]           eth_type,
  output logic [VC_W-1:0]       vlan_cnt,
  output logic [TCI_W-1:0]      vlan_tci,
  output logic [5:0]            hdr_len,
  output logic [IDX_W-1:0]      hdr_end_idx,
  output logic                  hdr_done,
`ifdef ETH_HDR_STATS_EN
  input  logic                  stats_clr,
  output logic [31:0]           stat_pkt,
  output logic [31:0]           stat_vlan,
  output logic [31:0]           stat_runt,
`endif
  output logic                  hdr_valid,
  output logic                  hdr_err
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(ETH_HDR_LEN + VLAN_TAG_LEN * MAX_VLAN + 1);
  localparam logic [OFF_W-1:0] OFF_DST_END = OFF_W'(5);
  localparam logic [OFF_W-1:0] OFF_SRC_END = OFF_W'(11);

  axis_reg_slice #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_tdata (s_tdata),
    .s_idx   (s_idx),
    .s_tvalid(s_tvalid),
    .s_tlast (s_tlast),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_idx   (m_idx),
    .m_tvalid(m_tvalid),
    .m_tlast (m_tlast),
    .m_tready(m_tready)
  );

  logic accept;
  assign accept = s_tvalid && s_tready;

  eth_state_e       st_q, st_d;
  logic [OFF_W-1:0] off_q, off_d;
  mac_addr_t        dst_q, dst_d, src_q, src_d;
  logic [7:0]       hi_q, hi_d;
  logic [15:0]      type_q, type_d;
  logic [VC_W-1:0]  vcnt_q, vcnt_d;
  logic [TCI_W-1:0] tci_q, tci_d;
  logic [5:0]       len_q, len_d;
  logic [IDX_W-1:0] end_q, end_d;
  logic             valid_q, valid_d, err_q, err_d, in_pkt_q, in_pkt_d, done_q;
  logic             sop, done_now, runt_now;

  always_comb begin
    logic [7:0]  b;
    logic [15:0] cand;
    st_d     = st_q;
    off_d    = off_q;
    dst_d    = dst_q;
    src_d    = src_q;
    hi_d     = hi_q;
    type_d   = type_q;
    vcnt_d   = vcnt_q;
    tci_d    = tci_q;
    len_d    = len_q;
    end_d    = end_q;
    valid_d  = valid_q;
    err_d    = err_q;
    in_pkt_d = in_pkt_q;
    sop      = 1'b0;
    done_now = 1'b0;
    runt_now = 1'b0;
    b        = '0;
    cand     = '0;
    if (accept) begin
      sop      = !in_pkt_q;
      in_pkt_d = !s_tlast;
      if (sop) begin
        st_d    = S_DST;
        off_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        vcnt_d  = '0;
        tci_d   = '0;
      end
      // Two-byte fields always start on an even offset, so off_d[0] selects the byte.
      for (int unsigned i = 0; i < BYTES; i++) begin
        b = s_tdata[8*i +: 8];
        if ((i <= 32'(s_idx)) && (st_d != S_DONE)) begin
          unique case (st_d)
            S_DST: begin
              dst_d = {dst_d[39:0], b};
              if (off_d == OFF_DST_END) st_d = S_SRC;
            end
            S_SRC: begin
              src_d = {src_d[39:0], b};
              if (off_d == OFF_SRC_END) st_d = S_TYPE;
            end
            S_TYPE: begin
              if (!off_d[0]) begin
                hi_d = b;
              end else begin
                cand = {hi_d, b};
                if (is_tpid(cand) && (32'(vcnt_d) < MAX_VLAN)) begin
                  st_d = S_TCI;
                end else begin
                  type_d   = cand;
                  st_d     = S_DONE;
                  done_now = 1'b1;
                  valid_d  = 1'b1;
                  end_d    = IDX_W'(i);
                  len_d    = 6'(ETH_HDR_LEN + VLAN_TAG_LEN * 32'(vcnt_d));
                end
              end
            end
            S_TCI: begin
              if (!off_d[0]) begin
                hi_d = b;
              end else begin
                tci_d[16*int'(vcnt_d) +: 16] = {hi_d, b};
                vcnt_d = vcnt_d + VC_W'(1);
                st_d   = S_TYPE;
              end
            end
            default: ;
          endcase
          off_d = off_d + OFF_W'(1);
        end
      end
      if (s_tlast && (st_d != S_DONE)) runt_now = 1'b1;
      if (runt_now) begin
        err_d = 1'b1;
        st_d  = S_DST;
        off_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= S_DST;
      off_q    <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      hi_q     <= '0;
      type_q   <= '0;
      vcnt_q   <= '0;
      tci_q    <= '0;
      len_q    <= '0;
      end_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      in_pkt_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      off_q    <= off_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      hi_q     <= hi_d;
      type_q   <= type_d;
      vcnt_q   <= vcnt_d;
      tci_q    <= tci_d;
      len_q    <= len_d;
      end_q    <= end_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      in_pkt_q <= in_pkt_d;
      done_q   <= done_now;
    end
  end

  assign dst_mac     = dst_q;
  assign src_mac     = src_q;
  assign eth_type    = type_q;
  assign vlan_cnt    = vcnt_q;
  assign vlan_tci    = tci_q;
  assign hdr_len     = len_q;
  assign hdr_end_idx = end_q;
  assign hdr_done    = done_q;
  assign hdr_valid   = valid_q;
  assign hdr_err     = err_q;

`ifdef ETH_HDR_STATS_EN
  logic [31:0] stat_pkt_q, stat_vlan_q, stat_runt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_q  <= '0;
      stat_vlan_q <= '0;
      stat_runt_q <= '0;
    end else if (stats_clr) begin
      stat_pkt_q  <= '0;
      stat_vlan_q <= '0;
      stat_runt_q <= '0;
    end else begin
      if (sop) stat_pkt_q <= stat_pkt_q + 32'd1;
      if (done_now && (vcnt_d != '0)) stat_vlan_q <= stat_vlan_q + 32'd1;
      if (runt_now) stat_runt_q <= stat_runt_q + 32'd1;
    end
  end

  assign stat_pkt  = stat_pkt_q;
  assign stat_vlan = stat_vlan_q;
  assign stat_runt = stat_runt_q;
`endif

endmodule

// File: doc/eth_hdr_parser_vlan.md
Name: eth_hdr_parser_vlan

Overview:
- Parametrised successor to the fixed-width Ethernet header parser.
- Extracts DST/SRC MAC, up to MAX_VLAN stacked 802.1Q/802.1ad tags and the inner EtherType from a byte-packed stream of any beat width.
- Forwards the stream unchanged through a one-stage ready/valid register slice. Unlike its predecessor, it honours downstream backpressure.
- Sits between the RX stream front-end and the IPv4 parser. It reports header length and header-end byte lane so the next stage can locate the L3 start.

Parameters:
- DATA_WIDTH, 64: beat width in bits. Multiple of 8, range 16..512.
- MAX_VLAN, 2: maximum number of VLAN tags parsed (0..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_tdata  in  DATA_WIDTH  input beat; byte 0 at bits [7:0] is the earliest wire byte
- s_idx  in  $clog2(DATA_WIDTH/8)  index of the last valid byte in the beat (lanes 0..s_idx are valid)
- s_tvalid  in  1  input valid
- s_tlast  in  1  last beat of packet
- s_tready  out  1  input ready
- m_tdata / m_idx / m_tvalid / m_tlast  out  as s_*  forwarded beat
- m_tready  in  1  downstream ready
- dst_mac  out  48  destination MAC
- src_mac  out  48  source MAC
- eth_type  out  16  inner EtherType, after all parsed tags
- vlan_cnt  out  $clog2(MAX_VLAN+1)  number of tags parsed
- vlan_tci  out  16*MAX_VLAN  TCI of tag k at [16k +: 16]; tag 0 is outermost
- hdr_len  out  6  header bytes: 14+4*vlan_cnt
- hdr_end_idx  out  $clog2(DATA_WIDTH/8)  lane of the last header byte within m_tdata
- hdr_done  out  1  one-cycle pulse, aligned with the m_* beat that carries the last header byte
- hdr_valid  out  1  level; header fields stable; held until the next SOP is accepted
- hdr_err  out  1  level; runt packet (tlast before header complete); held until the next SOP

Behaviour:
- Reset values: all outputs 0, except s_tready, which is 1 (the register slice is empty). In-packet flag 0, byte offset 0, state S_DST.
- Handshake:
  - Input is accepted when s_tvalid && s_tready, where s_tready = m_tready || !m_tvalid.
  - Latency is exactly 1 accepted cycle; data passes through unmodified.
  - When m_tvalid && !m_tready, the m_* outputs are held stable.
- SOP: the first accepted beat while the in-packet flag is 0. The flag sets on an accepted non-last beat and clears on an accepted tlast beat.
- SOP clears hdr_valid, hdr_err, vlan_cnt and vlan_tci in the same cycle it processes its own bytes.
- Byte offset counter: width $clog2(14+4*MAX_VLAN+1); saturates once the header is done.
- Per accepted beat, lanes 0..s_idx are walked in order while the header is incomplete. State machine:
  - S_DST, offsets 0-5: dst_mac, MSB first.
  - S_SRC, offsets 6-11: src_mac, MSB first.
  - S_TYPE, 2 bytes: capture a candidate type.
    - If the candidate is 0x8100 or 0x88A8 and vlan_cnt < MAX_VLAN, go to S_TCI.
    - Otherwise the candidate becomes eth_type and the state goes to S_DONE.
  - S_TCI, 2 bytes: store vlan_tci[vlan_cnt], increment vlan_cnt, return to S_TYPE.
  - S_DONE: ignore remaining bytes until the next SOP.
- A TPID seen after MAX_VLAN tags is reported as eth_type, not an error.
- Entering S_DONE sets hdr_valid=1, hdr_len and hdr_end_idx, and pulses hdr_done with the forwarded beat. Multiple state transitions within one beat are legal.
- Runt: an accepted tlast beat that ends before S_DONE sets hdr_err=1. hdr_valid stays 0 and the state returns to S_DST.
- tlast on the same beat that completes the header: hdr_valid=1, no error.
- s_tvalid without s_tready: no state or field change.
- Reset mid-packet: everything returns to reset values. The next accepted beat is treated as SOP.
- Header fields update on input acceptance, so they are valid no later than the m_* beat flagged by hdr_done.

Optional Feature:
- Macro ETH_HDR_STATS_EN.
- When defined, adds three 32-bit wrapping output counters and a clear input: stat_pkt (packets accepted), stat_vlan (packets with vlan_cnt > 0) and stat_runt (hdr_err events), plus stats_clr (in, 1, synchronous clear).
- stat_pkt counts at SOP; stat_vlan and stat_runt count on the event cycle. Counters reset to 0.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package eth_pkg:
  - Constants ETH_TYPE_VLAN=16'h8100, ETH_TYPE_QINQ=16'h88A8, ETH_HDR_LEN=14, VLAN_TAG_LEN=4.
  - Typedefs mac_addr_t (logic [47:0]) and eth_state_e (S_DST, S_SRC, S_TYPE, S_TCI, S_DONE).
- Sub-module axis_reg_slice (DATA_WIDTH, IDX_W): the one-stage ready/valid pipeline register, reusable by later parser stages.

Test Plan:
- Untagged 64-byte frame at DATA_WIDTH=64 with idx=7 every beat, DST 00:11:22:33:44:55, SRC 66:77:88:99:AA:BB, type 0x0800 → hdr_done on beat 2, hdr_end_idx=5, hdr_len=14, vlan_cnt=0, hdr_valid=1.
- QinQ frame with 0x88A8 TCI 0x0064 then 0x8100 TCI 0x00C8, inner type 0x86DD, MAX_VLAN=2 → vlan_cnt=2, vlan_tci={0x00C8,0x0064}, eth_type=0x86DD, hdr_len=22, hdr_end_idx=5 on beat 3.
- Three stacked tags with MAX_VLAN=2 → vlan_cnt=2, eth_type=0x8100, hdr_len=22, hdr_err=0.
- Runt frame of 10 bytes with tlast on beat 2 (idx=1) → hdr_err=1, hdr_valid=0; the next frame parses correctly and clears hdr_err at its SOP.
- Random m_tready at 50% plus random s_tvalid gaps over 1000 frames → output stream byte-identical to input; all fields match the model; m_* stable while stalled.
- DATA_WIDTH=16, one VLAN tag TCI 0xA00A → header completes on beat 9 at lane 1, hdr_len=18; reset asserted mid-frame returns all outputs to 0.
